axis_pkt_rr_arbiter: RTL

//  Packet-atomic arbiter for two AXI-Stream sources (A, B) onto one AXI-Stream sink.

---
 rtl/axis_pkt_rr_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-atomic two-source AXI-Stream arbiter with a single registered output stage.
// Latency is one cycle from input beat to m_axis_tvalid; sources stall whenever the output register is full and not drained.
module axis_pkt_rr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  prio_mode,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_A,
   input  logic                  s_axis_tvalid_A,
   output logic                  s_axis_tready_A,
   input  logic                  s_axis_tlast_A,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_B,
   input  logic                  s_axis_tvalid_B,
   output logic                  s_axis_tready_B,
   input  logic                  s_axis_tlast_B,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tid,
   output logic                  grant_a,
   output logic                  grant_b,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_a,
   output logic [CNT_WIDTH-1:0]  pkt_cnt_b
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic                  tid_q, tid_d;
   logic [CNT_WIDTH-1:0]  cnt_a_q, cnt_a_d;
   logic [CNT_WIDTH-1:0]  cnt_b_q, cnt_b_d;

   logic ready_int;
   logic acc_a;
   logic acc_b;

   // The output register can take a new beat when empty or being drained this cycle.
   assign ready_int = !tvalid_q || m_axis_tready;
   assign acc_a     = s_axis_tvalid_A && s_axis_tready_A;
   assign acc_b     = s_axis_tvalid_B && s_axis_tready_B;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // last_grant: 0 = A, 1 = B; reset to B so A wins the first contested round.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (s_axis_tvalid_A && s_axis_tvalid_B) begin
               if (prio_mode || last_grant_q) begin
                  state_d = GRANT_A;
               end else begin
                  state_d = GRANT_B;
               end
            end else if (s_axis_tvalid_A) begin
               state_d = GRANT_A;
            end else if (s_axis_tvalid_B) begin
               state_d = GRANT_B;
            end
         end
         GRANT_A: begin
            if (acc_a && s_axis_tlast_A) begin
               state_d      = IDLE;
               last_grant_d = 1'b0;
            end
         end
         GRANT_B: begin
            if (acc_b && s_axis_tlast_B) begin
               state_d      = IDLE;
               last_grant_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      grant_a         = (state_q == GRANT_A);
      grant_b         = (state_q == GRANT_B);
      s_axis_tready_A = grant_a && ready_int;
      s_axis_tready_B = grant_b && ready_int;
   end

   always_comb begin
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tid_d    = tid_q;
      if (acc_a) begin
         tdata_d  = s_axis_tdata_A;
         tlast_d  = s_axis_tlast_A;
         tid_d    = 1'b0;
         tvalid_d = 1'b1;
      end else if (acc_b) begin
         tdata_d  = s_axis_tdata_B;
         tlast_d  = s_axis_tlast_B;
         tid_d    = 1'b1;
         tvalid_d = 1'b1;
      end else if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end
   end

   // Packet counters wrap freely.
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (acc_a && s_axis_tlast_A) begin
         cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
      end
      if (acc_b && s_axis_tlast_B) begin
         cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tid_q    <= 1'b0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
      end else begin
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tid_q    <= tid_d;
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tid    = tid_q;
   assign pkt_cnt_a     = cnt_a_q;
   assign pkt_cnt_b     = cnt_b_q;

endmodule
